// File: rtl/pcie_dllp_tx_sched_if.sv
// DLLP scheduler bus: requester side, CRC engine handshake and framing-side valid/ready.
// The master modport is the scheduler's view; slave is the surrounding logic.
interface pcie_dllp_tx_sched_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]    req_ack;
  logic               crc_fd;
  logic               crc_nd;
  logic [31:0]        crc_d;
  logic               crc_rdy;
  logic [15:0]        crc_c;
  logic               tx_valid;
  logic               tx_ready;
  logic [47:0]        tx_dllp;
  logic [2:0]         tx_src;

  modport master (
    input  req_valid, req_data, crc_rdy, crc_c, tx_ready,
    output req_ack, crc_fd, crc_nd, crc_d, tx_valid, tx_dllp, tx_src
  );

  modport slave (
    output req_valid, req_data, crc_rdy, crc_c, tx_ready,
    input  req_ack, crc_fd, crc_nd, crc_d, tx_valid, tx_dllp, tx_src
  );
endinterface

// File: rtl/pcie_dllp_tx_sched.sv
// DLLP transmit scheduler: strict-priority/round-robin arbitration with a starvation guard,
// one-shot CRC engine sequencing with timeout, and valid/ready hand-off of {payload, crc}.
module pcie_dllp_tx_sched #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned CRC_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  pcie_dllp_tx_sched_if.master   bus,
  output logic                   busy,
  output logic                   crc_err
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned TW = $clog2(CRC_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, SEND} state_t;

  state_t          state, state_nxt;
  logic [2:0]      rr_ptr;
  logic [SW-1:0]   starve_cnt;
  logic [TW-1:0]   tout_cnt;
  logic [31:0]     pay_q;
  logic [15:0]     crc_q;
  logic [2:0]      src_q;
  logic [NREQ-1:0] ack_q;
  logic            err_q;

  logic            others_pend;
  logic            gnt_any;
  logic            gnt_zero;
  logic            found;
  logic [2:0]      gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic [31:0]     gnt_data;

  always_comb begin
    others_pend = |bus.req_valid[NREQ-1:1];
    gnt_any     = |bus.req_valid;
    gnt_zero    = bus.req_valid[0] && !(starve_cnt == SW'(STARVE_MAX) && others_pend);
    gnt_idx     = '0;
    found       = gnt_zero;
    // Cyclic search from rr_ptr: first pass covers rr_ptr..NREQ-1, second wraps to 1..rr_ptr-1.
    for (int unsigned k = 1; k < NREQ; k++) begin
      if (!found && bus.req_valid[k] && (3'(k) >= rr_ptr)) begin
        gnt_idx = 3'(k);
        found   = 1'b1;
      end
    end
    for (int unsigned k = 1; k < NREQ; k++) begin
      if (!found && bus.req_valid[k]) begin
        gnt_idx = 3'(k);
        found   = 1'b1;
      end
    end
    gnt_oh   = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == 3'(i)) begin
        gnt_oh[i] = 1'b1;
        gnt_data  = bus.req_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (gnt_any) state_nxt = LOAD;
      LOAD: state_nxt = WAIT;
      WAIT: begin
        if (bus.crc_rdy)                           state_nxt = SEND;
        else if (tout_cnt == TW'(CRC_TIMEOUT - 1)) state_nxt = IDLE;
      end
      SEND: if (bus.tx_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= 3'd1;
      starve_cnt <= '0;
      tout_cnt   <= '0;
      pay_q      <= '0;
      crc_q      <= '0;
      src_q      <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            pay_q <= gnt_data;
            src_q <= gnt_idx;
            ack_q <= gnt_oh;
            if (gnt_idx != 3'd0) begin
              rr_ptr     <= (gnt_idx == 3'(NREQ - 1)) ? 3'd1 : gnt_idx + 3'd1;
              starve_cnt <= '0;
            end else if (others_pend) begin
              if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        LOAD: tout_cnt <= '0;
        WAIT: begin
          if (bus.crc_rdy)                           crc_q    <= bus.crc_c;
          else if (tout_cnt == TW'(CRC_TIMEOUT - 1)) err_q    <= 1'b1;
          else                                       tout_cnt <= tout_cnt + TW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ack  = ack_q;
  assign bus.crc_nd   = (state == LOAD);
  assign bus.crc_fd   = bus.crc_nd;
  assign bus.crc_d    = pay_q;
  assign bus.tx_valid = (state == SEND);
  assign bus.tx_dllp  = {pay_q, crc_q};
  assign bus.tx_src   = src_q;
  assign busy         = (state != IDLE);
  assign crc_err      = err_q;

endmodule

// File: tb/tb_pcie_dllp_tx_sched.sv
// Directed bench for pcie_dllp_tx_sched with a one-cycle CRC engine model.
module tb_pcie_dllp_tx_sched;
  localparam int unsigned NREQ = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic        crc_err;
  logic        crc_en;
  logic [15:0] crc_val;
  int          total = 0;
  int          bad   = 0;

  pcie_dllp_tx_sched_if #(.NREQ(NREQ)) bus();

  pcie_dllp_tx_sched #(
    .NREQ(NREQ),
    .STARVE_MAX(4),
    .CRC_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .crc_err(crc_err)
  );

  always #5 clk = ~clk;

  // CRC engine: result one cycle after nd, suppressed when crc_en is low.
  always @(posedge clk) begin
    bus.crc_rdy <= crc_en && bus.crc_nd;
    bus.crc_c   <= crc_val;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int idx);
    idx = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req_ack != '0) begin
        check("ack_onehot", 64'($onehot(bus.req_ack)), 64'd1);
        for (int i = 0; i < NREQ; i++) if (bus.req_ack[i]) idx = i;
        break;
      end
    end
    check("ack_seen", 64'(|bus.req_ack), 64'd1);
  endtask

  task automatic wait_txv();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.tx_valid) break;
    end
    check("txv_seen", 64'(bus.tx_valid), 64'd1);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.tx_ready  = 1'b1;
    crc_en        = 1'b1;
    reset         = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  int idx;
  int rr_exp[6]  = '{1, 2, 3, 1, 2, 3};
  int stv_exp[10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};

  initial begin
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_ready  = 1'b0;
    crc_en        = 1'b1;
    crc_val       = 16'hABCD;
    repeat (2) @(negedge clk);
    check("rst_ack",  64'(bus.req_ack), 64'd0);
    check("rst_crc",  64'({bus.crc_nd, bus.crc_fd, bus.crc_d}), 64'd0);
    check("rst_tx",   64'({bus.tx_valid, bus.tx_dllp}), 64'd0);
    check("rst_src",  64'(bus.tx_src), 64'd0);
    check("rst_misc", 64'({busy, crc_err}), 64'd0);
    reset = 1'b1;

    // Single request from requester 1 with zero payload.
    bus.req_data  = {32'h33333333, 32'h22222222, 32'h00000000, 32'h0C0C0C0C};
    bus.tx_ready  = 1'b1;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    check("t1_ack",  64'(bus.req_ack), 64'h2);
    check("t1_nd",   64'({bus.crc_nd, bus.crc_fd}), 64'h3);
    check("t1_crcd", 64'(bus.crc_d), 64'h0);
    check("t1_busy", 64'(busy), 64'd1);
    bus.req_valid = '0;
    @(negedge clk);
    check("t1_n2", 64'({bus.tx_valid, bus.crc_nd, bus.req_ack}), 64'd0);
    @(negedge clk);
    check("t1_txv",  64'(bus.tx_valid), 64'd1);
    check("t1_dllp", 64'(bus.tx_dllp), 64'h0000_0000_ABCD);
    check("t1_src",  64'(bus.tx_src), 64'd1);
    @(negedge clk);
    check("t1_idle", 64'({busy, bus.tx_valid}), 64'd0);

    // Round-robin among 1..3.
    do_reset();
    bus.req_data  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h0C0C0C0C};
    bus.req_valid = 4'b1110;
    for (int k = 0; k < 6; k++) begin
      wait_ack(idx);
      check("rr_grant", 64'(idx), 64'(rr_exp[k]));
      if (k == 5) bus.req_valid = '0;
    end
    repeat (4) @(negedge clk);

    // Starvation guard between requesters 0 and 2.
    do_reset();
    bus.req_valid = 4'b0101;
    for (int k = 0; k < 10; k++) begin
      wait_ack(idx);
      check("stv_grant", 64'(idx), 64'(stv_exp[k]));
      if (k == 9) bus.req_valid = '0;
    end
    repeat (4) @(negedge clk);

    // Backpressure in SEND.
    do_reset();
    bus.tx_ready           = 1'b0;
    crc_val                = 16'h1234;
    bus.req_data[127:96]   = 32'hDEADBEEF;
    bus.req_valid          = 4'b1000;
    wait_ack(idx);
    check("bp_ack",  64'(idx), 64'd3);
    check("bp_crcd", 64'(bus.crc_d), 64'hDEADBEEF);
    bus.req_valid = 4'b0010;
    wait_txv();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 64'(bus.tx_valid), 64'd1);
      check("bp_dllp",  64'(bus.tx_dllp), 64'hDEADBEEF_1234);
      check("bp_src",   64'(bus.tx_src), 64'd3);
      check("bp_noack", 64'(bus.req_ack), 64'd0);
      @(negedge clk);
    end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    check("bp_idle", 64'({busy, bus.tx_valid}), 64'd0);
    @(negedge clk);
    check("bp_next", 64'(bus.req_ack), 64'h2);
    bus.req_valid = '0;
    repeat (4) @(negedge clk);

    // CRC timeout, then normal re-grant.
    do_reset();
    crc_en               = 1'b0;
    bus.req_data[95:64]  = 32'h5A5A5A5A;
    bus.req_valid        = 4'b0100;
    wait_ack(idx);
    check("to_ack", 64'(idx), 64'd2);
    bus.req_valid = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("to_wait", 64'({crc_err, busy, bus.tx_valid}), 64'b010);
    end
    @(negedge clk);
    check("to_err", 64'({crc_err, busy, bus.tx_valid}), 64'b100);
    @(negedge clk);
    check("to_errpulse", 64'(crc_err), 64'd0);
    crc_en        = 1'b1;
    crc_val       = 16'h0F0F;
    bus.req_valid = 4'b0100;
    wait_ack(idx);
    check("to_regrant", 64'(idx), 64'd2);
    bus.req_valid = '0;
    wait_txv();
    check("to_dllp", 64'(bus.tx_dllp), 64'h5A5A5A5A_0F0F);
    check("to_src",  64'(bus.tx_src), 64'd2);
    @(negedge clk);

    // Reset while waiting on the CRC engine.
    crc_en        = 1'b0;
    bus.req_valid = 4'b0010;
    wait_ack(idx);
    check("mr_ack0", 64'(idx), 64'd1);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    check("mr_inwait", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mr_crc",  64'({bus.crc_nd, bus.crc_fd, bus.crc_d}), 64'd0);
    check("mr_tx",   64'({bus.tx_valid, bus.tx_dllp}), 64'd0);
    check("mr_misc", 64'({bus.req_ack, bus.tx_src, busy, crc_err}), 64'd0);
    bus.req_valid = 4'b1000;
    @(negedge clk);
    check("mr_hold", 64'({bus.req_ack, crc_err}), 64'd0);
    reset                = 1'b1;
    crc_en               = 1'b1;
    crc_val              = 16'hC0DE;
    bus.req_data[127:96] = 32'h0BADF00D;
    @(negedge clk);
    check("mr_ack", 64'(bus.req_ack), 64'h8);
    check("mr_err", 64'(crc_err), 64'd0);
    bus.req_valid = '0;
    wait_txv();
    check("mr_dllp", 64'(bus.tx_dllp), 64'h0BADF00D_C0DE);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end
endmodule

// File: doc/pcie_dllp_tx_sched.md
# pcie_dllp_tx_sched

Data-link-layer DLLP transmit scheduler for the PCIe link. It arbitrates among up to NREQ DLLP sources (Ack/Nak, UpdateFC, PM), with strict priority for source 0 and round-robin among the rest. It sequences the 32-bit DLLP CRC-16 engine (fd/nd/rdy handshake) for each granted 4-byte payload. It then presents the 6-byte DLLP (payload plus CRC) to the framing logic over a valid/ready interface.

## Interface
- NREQ, 4: number of requesters, 2..8; requester 0 is the Ack/Nak source.
- STARVE_MAX, 4: maximum consecutive grants to requester 0 while any other requester is pending.
- CRC_TIMEOUT, 8: cycles allowed in WAIT for crc_rdy.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester DLLP pending; held until acked.
- req_data  in  NREQ*32  payload of requester i in bits [32i+31:32i].
- req_ack  out  NREQ  one-cycle one-hot pulse: payload i latched.
- crc_fd  out  1  first-data flag to the CRC engine; always equal to crc_nd.
- crc_nd  out  1  new-data strobe to the CRC engine.
- crc_d  out  32  payload to the CRC engine.
- crc_rdy  in  1  CRC engine result valid.
- crc_c  in  16  CRC engine result.
- tx_valid  out  1  DLLP available.
- tx_ready  in  1  downstream accepts the DLLP.
- tx_dllp  out  48  {payload[31:0], crc[15:0]}.
- tx_src  out  3  index of the requester whose DLLP is on tx_dllp.
- busy  out  1  state is not IDLE.
- crc_err  out  1  one-cycle pulse on CRC timeout.

## Operation
- States: IDLE, LOAD, WAIT, SEND.
- IDLE:
  - If any req_valid is high, compute the grant, latch req_data of the grantee, pulse req_ack[grant] and go to LOAD.
  - Otherwise stay in IDLE.
- Grant rule:
  - Requester 0 wins if req_valid[0] is high, unless starve_cnt == STARVE_MAX and some req_valid[1..NREQ-1] is high.
  - Otherwise the first valid requester at or after rr_ptr among 1..NREQ-1 wins, searching cyclically.
- Pointer and starvation counter:
  - Grant to requester k >= 1: rr_ptr <= (k == NREQ-1) ? 1 : k+1, and starve_cnt <= 0.
  - Grant to requester 0 while another requester is pending: starve_cnt increments, saturating at STARVE_MAX.
  - Grant to requester 0 with no other requester pending: starve_cnt <= 0.
- LOAD: drive crc_nd = crc_fd = 1 and crc_d = latched payload for exactly one cycle, clear the timeout counter, go to WAIT. These signals are 0 in every other state; crc_d holds its last value.
- WAIT:
  - On crc_rdy: latch crc_c and go to SEND.
  - Otherwise increment the timeout counter. When it reaches CRC_TIMEOUT: pulse crc_err, drop the DLLP, go to IDLE.
  - The requester is not re-acked after a timeout; it must re-assert req_valid.
- SEND:
  - tx_valid = 1; tx_dllp and tx_src are stable until the handshake.
  - On tx_valid && tx_ready, go to IDLE with tx_valid = 0 in the next cycle.
- Requests arriving during LOAD, WAIT or SEND are not evaluated until IDLE.
- A requester deasserting req_valid before ack simply loses eligibility.

## Timing
- Reset (reset low, asynchronous):
  - State IDLE, rr_ptr = 1, starve_cnt = 0.
  - All outputs 0: req_ack, crc_nd, crc_fd, crc_d, tx_valid, tx_dllp, tx_src, busy, crc_err.
  - Reset mid-operation discards any in-flight DLLP, with no ack repeat and no crc_err.
- Release: the first arbitration happens on the first rising edge with reset high.
- Cycle sequence with a CRC engine whose rdy follows nd by one cycle, request visible in IDLE at cycle N:
  - N+1: req_ack and crc_nd.
  - N+2: crc_rdy.
  - N+3: tx_valid.
- Minimum request-to-tx_valid latency is 3 cycles.
- Back-to-back throughput with tx_ready held high is one DLLP per 4 cycles.
- req_ack and crc_nd are asserted in the same cycle.
- crc_err is asserted in the cycle the state returns to IDLE.
- tx_valid must not drop without tx_ready.
- tx_ready while not in SEND is ignored.

## Test plan
- Single request: req_valid = 4'b0010 with payload 0x00000000, engine model returns crc_c = 0xABCD one cycle after nd -> req_ack = 4'b0010 at N+1, tx_valid at N+3, tx_dllp = 0x00000000ABCD, tx_src = 1.
- Round-robin: req_valid = 4'b1110 held, with each requester re-asserting after its ack -> grant order 1, 2, 3, 1, 2, 3; req_ack is one-hot every time.
- Starvation guard: req 0 and req 2 held continuously with STARVE_MAX = 4 -> grant order 0, 0, 0, 0, 2, 0, 0, 0, 0, 2.
- Backpressure: tx_ready low for 10 cycles in SEND -> tx_valid, tx_dllp and tx_src stable throughout; no new req_ack; IDLE the cycle after tx_ready rises.
- CRC timeout: crc_rdy never asserted -> crc_err pulse 8 cycles after WAIT entry, busy falls, no tx_valid; the re-asserted request is re-granted normally.
- Mid-operation reset: reset low during WAIT -> all outputs 0 immediately; after release, a pending req 3 wins at the first edge (rr_ptr = 1 search, req 0 idle).
